// File: rtl/arb_pkg.sv
// Shared types and helpers for the multi-mode arbiter: FSM states, mode
// encodings and index arithmetic.
package arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   localparam logic FIXED = 1'b0;
   localparam logic RR    = 1'b1;

   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Position visited at step off of the scan: rotated from base in RR mode.
   function automatic int scan_pos(input int base, input int off, input logic m, input int n);
      int p;
      p = (m == RR) ? (base + off) : off;
      if (p >= n) begin
         p = p - n;
      end else begin
         p = p + 0;
      end
      return p;
   endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational winner selection: fixed priority from index 0, or a
// rotating scan starting at ptr in round-robin mode.
module rr_prio_pick
   import arb_pkg::*;
#(
   parameter int N = 4,
   parameter int W = idx_w(N)
) (
   input  logic [N-1:0] cand,
   input  logic [W-1:0] ptr,
   input  logic         mode,
   output logic [N-1:0] win_oh,
   output logic [W-1:0] win_idx,
   output logic         any_vld
);

   logic found_s;

   // First set candidate in scan order wins.
   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      found_s = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found_s && cand[scan_pos(int'(ptr), i, mode, N)]) begin
            found_s = 1'b1;
            win_idx = W'(scan_pos(int'(ptr), i, mode, N));
            win_oh[scan_pos(int'(ptr), i, mode, N)] = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   assign any_vld = |cand;

endmodule

// File: rtl/multi_mode_arb.sv
// N-way arbiter with fixed-priority / round-robin modes and a per-owner
// hold limit; all outputs are registered.
module multi_mode_arb
   import arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8,
   localparam int W       = idx_w(N)
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [N-1:0] req,
   input  logic         mode,
   output logic [N-1:0] gnt,
   output logic [W-1:0] gnt_id,
   output logic         gnt_vld
);

   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
   localparam logic [7:0] HOLD_SAT = (MAX_HOLD == 0) ? 8'hFF : 8'(MAX_HOLD);

   state_t       state_r;
   logic [7:0]   hold_cnt_r;
   logic [W-1:0] ptr_r;
   logic [N-1:0] gnt_r;
   logic [W-1:0] gnt_id_r;
   logic         gnt_vld_r;

   logic         owner_req_s;
   logic         expire_s;
   logic         keep_s;
   logic [N-1:0] cand_s;
   logic [N-1:0] win_oh_s;
   logic [W-1:0] win_idx_s;
   logic         any_vld_s;
   logic [W-1:0] next_ptr_s;

   // Owner keeps the grant unless it releases or its hold budget expires while others wait.
   always_comb begin
      owner_req_s = (state_r == OWN) && req[gnt_id_r];
      expire_s    = owner_req_s && (MAX_HOLD != 0) && (hold_cnt_r == HOLD_MAX)
                    && (|(req & ~gnt_r));
      keep_s      = owner_req_s && !expire_s;
      if (expire_s) begin
         cand_s = req & ~gnt_r;
      end else begin
         cand_s = req;
      end
      if (win_idx_s == W'(N - 1)) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = win_idx_s + W'(1);
      end
   end

   rr_prio_pick #(
      .N (N),
      .W (W)
   ) u_pick (
      .cand    (cand_s),
      .ptr     (ptr_r),
      .mode    (mode),
      .win_oh  (win_oh_s),
      .win_idx (win_idx_s),
      .any_vld (any_vld_s)
   );

   // Arbitration FSM with registered grant outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r    <= IDLE;
         hold_cnt_r <= 8'd0;
         ptr_r      <= '0;
         gnt_r      <= '0;
         gnt_id_r   <= '0;
         gnt_vld_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (any_vld_s) begin
                  state_r    <= OWN;
                  hold_cnt_r <= 8'd1;
                  ptr_r      <= next_ptr_s;
                  gnt_r      <= win_oh_s;
                  gnt_id_r   <= win_idx_s;
                  gnt_vld_r  <= 1'b1;
               end else begin
                  state_r    <= IDLE;
                  hold_cnt_r <= 8'd0;
                  gnt_r      <= '0;
                  gnt_id_r   <= '0;
                  gnt_vld_r  <= 1'b0;
               end
            end
            OWN: begin
               if (keep_s) begin
                  hold_cnt_r <= (hold_cnt_r == HOLD_SAT) ? hold_cnt_r : hold_cnt_r + 8'd1;
               end else if (any_vld_s) begin
                  hold_cnt_r <= 8'd1;
                  ptr_r      <= next_ptr_s;
                  gnt_r      <= win_oh_s;
                  gnt_id_r   <= win_idx_s;
                  gnt_vld_r  <= 1'b1;
               end else begin
                  state_r    <= IDLE;
                  hold_cnt_r <= 8'd0;
                  gnt_r      <= '0;
                  gnt_id_r   <= '0;
                  gnt_vld_r  <= 1'b0;
               end
            end
            default: begin
               state_r    <= IDLE;
               hold_cnt_r <= 8'd0;
               gnt_r      <= '0;
               gnt_id_r   <= '0;
               gnt_vld_r  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt     = gnt_r;
   assign gnt_id  = gnt_id_r;
   assign gnt_vld = gnt_vld_r;

endmodule

// File: tb/tb_multi_mode_arb.sv
// Directed self-checking bench for multi_mode_arb with N=4, MAX_HOLD=4.
module tb_multi_mode_arb;

   logic       clk;
   logic       rstn;
   logic [3:0] req;
   logic       mode;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_vld;

   int tests_run;
   int tests_failed;

   multi_mode_arb #(
      .N        (4),
      .MAX_HOLD (4)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .req     (req),
      .mode    (mode),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_vld (gnt_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      req  = 4'b0000;
      mode = 1'b0;
      tick();
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      req  = 4'b1111;
      mode = 1'b1;
      tick();
      tick();
      tests_run++;
      if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_id !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_hold: gnt=%b vld=%b id=%0d expected 0000/0/0", gnt, gnt_vld, gnt_id);
      end
      req  = 4'b0000;
      rstn = 1'b1;
      tick();
      tests_run++;
      if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_id !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_idle_noreq: gnt=%b vld=%b id=%0d expected 0000/0/0", gnt, gnt_vld, gnt_id);
      end
   endtask

   task automatic test_fixed();
      logic [3:0] exp_g;
      logic [1:0] exp_id;
      do_reset();
      mode = 1'b0;
      req  = 4'b1010;
      for (int k = 1; k <= 12; k++) begin
         tick();
         exp_g  = (((k - 1) / 4) % 2 == 0) ? 4'b0010 : 4'b1000;
         exp_id = (((k - 1) / 4) % 2 == 0) ? 2'd1 : 2'd3;
         tests_run++;
         if (gnt !== exp_g || gnt_id !== exp_id || gnt_vld !== 1'b1) begin
            tests_failed++;
            $display("FAIL fixed_hold cycle %0d: gnt=%b id=%0d vld=%b expected %b/%0d/1",
                     k, gnt, gnt_id, gnt_vld, exp_g, exp_id);
         end
      end
      req = 4'b0000;
      tick();
      tests_run++;
      if (gnt !== 4'b0000 || gnt_id !== 2'd0 || gnt_vld !== 1'b0) begin
         tests_failed++;
         $display("FAIL fixed_release_idle: gnt=%b id=%0d vld=%b expected 0000/0/0", gnt, gnt_id, gnt_vld);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g;
      do_reset();
      mode = 1'b1;
      req  = 4'b1111;
      for (int k = 1; k <= 20; k++) begin
         tick();
         exp_g = 4'b0001 << (((k - 1) / 4) % 4);
         tests_run++;
         if (gnt !== exp_g || gnt_vld !== 1'b1) begin
            tests_failed++;
            $display("FAIL rr_rotate cycle %0d: gnt=%b vld=%b expected %b/1", k, gnt, gnt_vld, exp_g);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      mode = 1'b1;
      req  = 4'b0100;
      tick();
      tests_run++;
      if (gnt !== 4'b0100) begin
         tests_failed++;
         $display("FAIL b2b_first: gnt=%b expected 0100", gnt);
      end
      req = 4'b0101;
      tick();
      tests_run++;
      if (gnt !== 4'b0100) begin
         tests_failed++;
         $display("FAIL b2b_owner_keeps: gnt=%b expected 0100", gnt);
      end
      req = 4'b0001;
      tick();
      tests_run++;
      if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_vld !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_handover: gnt=%b id=%0d vld=%b expected 0001/0/1", gnt, gnt_id, gnt_vld);
      end
   endtask

   task automatic test_single_saturate();
      do_reset();
      mode = 1'b0;
      req  = 4'b0100;
      for (int k = 1; k <= 20; k++) begin
         tick();
         tests_run++;
         if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
            tests_failed++;
            $display("FAIL single_hold cycle %0d: gnt=%b id=%0d expected 0100/2", k, gnt, gnt_id);
         end
      end
      // Saturated counter means the newcomer takes over at the very next edge.
      req = 4'b0101;
      tick();
      tests_run++;
      if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
         tests_failed++;
         $display("FAIL single_saturated_expiry: gnt=%b id=%0d expected 0001/0", gnt, gnt_id);
      end
   endtask

   task automatic test_reset_mid_own();
      do_reset();
      mode = 1'b0;
      req  = 4'b1000;
      tick();
      tests_run++;
      if (gnt !== 4'b1000) begin
         tests_failed++;
         $display("FAIL midrst_setup: gnt=%b expected 1000", gnt);
      end
      req  = 4'b1111;
      mode = 1'b1;
      rstn = 1'b0;
      #1;
      tests_run++;
      if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_id !== 2'd0) begin
         tests_failed++;
         $display("FAIL midrst_async: gnt=%b vld=%b id=%0d expected 0000/0/0", gnt, gnt_vld, gnt_id);
      end
      tick();
      rstn = 1'b1;
      tick();
      tests_run++;
      if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_vld !== 1'b1) begin
         tests_failed++;
         $display("FAIL midrst_ptr_zero: gnt=%b id=%0d vld=%b expected 0001/0/1", gnt, gnt_id, gnt_vld);
      end
   endtask

   task automatic test_mode_switch();
      logic [3:0] exp_seq [4];
      logic [3:0] exp_g;
      exp_seq[0] = 4'b1000;
      exp_seq[1] = 4'b0010;
      exp_seq[2] = 4'b0100;
      exp_seq[3] = 4'b1000;
      do_reset();
      mode = 1'b0;
      req  = 4'b1000;
      tick();
      tests_run++;
      if (gnt !== 4'b1000) begin
         tests_failed++;
         $display("FAIL modesw_setup: gnt=%b expected 1000", gnt);
      end
      mode = 1'b1;
      req  = 4'b1110;
      for (int k = 2; k <= 16; k++) begin
         tick();
         exp_g = exp_seq[(k - 1) / 4];
         tests_run++;
         if (gnt !== exp_g) begin
            tests_failed++;
            $display("FAIL modesw_seq cycle %0d: gnt=%b expected %b", k, gnt, exp_g);
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rstn = 1'b0;
      req  = 4'b0000;
      mode = 1'b0;
      test_reset();
      test_fixed();
      test_round_robin();
      test_back_to_back();
      test_single_saturate();
      test_reset_mid_own();
      test_mode_switch();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/multi_mode_arb.md
MULTI_MODE_ARB -- requirements
Module: multi_mode_arb

Interface
REQ-001 Parameter N, default 4: number of requesters; legal range 2..16.
REQ-002 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles per owner while others wait; 0 = unlimited; legal range 0..255.
REQ-003 Port clk  input  1: clock; all state updates on rising edge.
REQ-004 Port rstn  input  1: reset, asynchronous, active-low.
REQ-005 Port req  input  N: request per requester; bit 0 = requester 0.
REQ-006 Port mode  input  1: 0 = fixed priority (index 0 highest), 1 = round-robin.
REQ-007 Port gnt  output  N: registered one-hot grant, or all-zero.
REQ-008 Port gnt_id  output  clog2(N): binary index of the granted requester; 0 when gnt_vld=0.
REQ-009 Port gnt_vld  output  1: high when any gnt bit is high.

Function
REQ-010 FSM states: IDLE (no owner) and OWN (one owner holds grant); all outputs are registers.
REQ-011 Arbitration latency is 1 cycle: a decision made on sampled req appears on gnt at the next edge.
REQ-012 IDLE with req=0: stay IDLE, gnt=0.
REQ-013 IDLE with req!=0: pick winner per mode; next cycle gnt=onehot(winner), state OWN, hold_cnt=1.
REQ-014 Fixed mode winner: lowest set index among candidates.
REQ-015 Round-robin winner: first set candidate scanning upward from ptr, wrapping N-1 -> 0.
REQ-016 ptr is updated to (winner+1) mod N on every new grant in both modes, so switching to round-robin starts fairly.
REQ-017 OWN, req[owner]=1, and (MAX_HOLD=0 or hold_cnt<MAX_HOLD or no other req): keep grant; hold_cnt increments, saturating at MAX_HOLD.
REQ-018 OWN, req[owner]=1, MAX_HOLD!=0, hold_cnt=MAX_HOLD, another req pending: re-arbitrate with owner masked out; next cycle the new winner is granted with hold_cnt=1.
REQ-019 OWN, req[owner]=0: re-arbitrate the same cycle over current req; next cycle grant the new winner (hold_cnt=1), or go to IDLE with gnt=0 if req=0.
REQ-020 A deasserting owner must not lose a cycle: a release at cycle t with another req pending gives the new grant at t+1.
REQ-021 A change of mode takes effect only at the next arbitration; a current owner is never pre-empted by a mode change.
REQ-022 A requester that drops req while not granted is simply not a candidate; no request memory is kept.
REQ-023 gnt is always one-hot or zero; gnt, gnt_id and gnt_vld change on the same edge.

Reset
REQ-024 Asserting rstn low immediately forces gnt=0, gnt_id=0, gnt_vld=0, state=IDLE, ptr=0 and hold_cnt=0, including mid-ownership.
REQ-025 After rstn deasserts, the first arbitration follows the IDLE rules; req sampled during reset is ignored.

Structure
REQ-026 Shared package arb_pkg holds the state enum (IDLE, OWN), the mode encoding constants (FIXED=0, RR=1) and a clog2-based index-width function.
REQ-027 Sub-module rr_prio_pick (combinational): inputs are the candidate vector, start pointer and mode; outputs are the winner one-hot, winner index and any_valid; it is instantiated once.
REQ-028 The masking of the owner for MAX_HOLD expiry is applied to the candidate vector before rr_prio_pick.

Verification (N=4, MAX_HOLD=4)
REQ-029 mode=0, req=4'b1010 held -> gnt=4'b0010 one cycle later; at hold_cnt=4 gnt=4'b1000 the next cycle, then 4'b0010 again after 4 more cycles.
REQ-030 mode=1, req=4'b1111 held -> grants 0001, 0010, 0100, 1000, 0001, each lasting 4 cycles.
REQ-031 mode=1, owner 2 drops req at cycle t while req[0]=1 -> gnt=4'b0001 at t+1, with no idle cycle.
REQ-032 Single req=4'b0100 held for 20 cycles -> gnt=4'b0100 for the whole time (no other req) and hold_cnt saturates at 4.
REQ-033 rstn pulsed low during OWN with gnt=4'b1000 -> gnt=0, gnt_vld=0 and gnt_id=0 asynchronously; after release with req=4'b1111 and mode=1 -> gnt=4'b0001 (ptr=0).
REQ-034 mode toggled 0 -> 1 while owner 3 holds the grant -> grant is unchanged until expiry or release; the next winner is chosen round-robin starting from index 0 (ptr=(3+1) mod 4).
